// File: rtl/tfs_pkg.sv
// tfs_pkg: shared types, constants and helpers for tetris_frame_serializer.
//   tfs_frame_t   : one captured game {game_id, fail, board, total}
//   tfs_state_e   : readout FSM states
//   tfs_sat255    : saturating 8-bit score accumulation
//   tfs_beat_byte : maps a frame and a beat index (0..13) to its payload byte
// Optional feature macro: TFS_PARITY_EN (adds even parity on row beats, bit 7).
package tfs_pkg;

  localparam int unsigned TFS_ROWS     = 12;
  localparam int unsigned TFS_COLS     = 6;
  localparam int unsigned TFS_BEATS    = 14;
  localparam logic        TFS_HDR_MARK = 1'b1;
  localparam int unsigned TFS_ID_W     = 6;
  localparam int unsigned TFS_BOARD_W  = TFS_ROWS * TFS_COLS;

  typedef struct packed {
    logic [TFS_ID_W-1:0]    game_id;
    logic                   fail;
    logic [TFS_BOARD_W-1:0] board;
    logic [7:0]             total;
  } tfs_frame_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tfs_state_e;

  function automatic logic [7:0] tfs_sat255(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Beat 0 is the header, beats 1..12 walk rows from top (11) down to bottom (0),
  // beat 13 carries the total.
  function automatic logic [7:0] tfs_beat_byte(input tfs_frame_t f, input logic [3:0] beat);
    logic [7:0]  b;
    logic [5:0]  row;
    int unsigned idx;
    b   = '0;
    row = '0;
    idx = 0;
    if (beat == 4'd0) begin
      b = {TFS_HDR_MARK, f.fail, f.game_id};
    end else if (beat == 4'd13) begin
      b = f.total;
    end else if (beat <= 4'd12) begin
      idx = TFS_ROWS - int'(beat);
      row = f.board[idx*TFS_COLS +: TFS_COLS];
`ifdef TFS_PARITY_EN
      b = {^row, 1'b0, row};
`else
      b = {2'b00, row};
`endif
    end
    return b;
  endfunction

endpackage

// File: rtl/tfs_frame_fifo.sv
// tfs_frame_fifo: DEPTH-entry synchronous FIFO of tfs_frame_t.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write request (accepted when not full, or when full with a pop)
//   pop            : remove head entry (ignored when empty)
//   head           : current head entry (valid when !empty)
//   head_next      : entry behind the head (valid when count >= 2)
//   full/empty/count : occupancy
module tfs_frame_fifo
  import tfs_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  tfs_frame_t               push_data,
  input  logic                     pop,
  output tfs_frame_t               head,
  output tfs_frame_t               head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  tfs_frame_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    do_pop    = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    do_push   = push && (!full || do_pop);
    head      = mem[rd_ptr];
    head_next = mem[rd_ptr + AW'(1)];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/tetris_frame_serializer.sv
// tetris_frame_serializer: accumulates per-game score, captures the final
// 6x12 board on tetris_valid, and streams each game as a 14-beat byte frame.
//   clk, rst               : clock, synchronous active-high reset
//   score_valid, score     : per-placement score strobe and value
//   fail, tetris_valid     : end-of-game strobe with overflow flag
//   tetris                 : final board, bit 6*r+c
//   out_valid/out_ready    : output stream handshake
//   out_data, out_last     : beat payload, high on beat 13
//   overflow, drop_cnt     : sticky drop flag, saturating dropped-game count
// Optional feature macro: TFS_PARITY_EN (row beats carry even parity in bit 7).
module tetris_frame_serializer
  import tfs_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned GAME_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_valid,
  input  logic [3:0]  score,
  input  logic        fail,
  input  logic        tetris_valid,
  input  logic [71:0] tetris,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tfs_state_e        state;
  logic [3:0]        beat;
  logic [7:0]        acc;
  logic [GAME_W-1:0] game_cnt;

  tfs_frame_t        in_frame;
  tfs_frame_t        fifo_head;
  tfs_frame_t        fifo_head_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic              handshake;
  logic              pop_now;
  logic              push_now;
  logic              drop_now;

  always_comb begin
    handshake        = out_valid && out_ready;
    pop_now          = (state == SEND) && handshake && (beat == 4'd13) && !fifo_empty;
    push_now         = tetris_valid && (!fifo_full || pop_now);
    drop_now         = tetris_valid && fifo_full && !pop_now;
    in_frame.game_id = TFS_ID_W'(game_cnt);
    in_frame.fail    = fail;
    in_frame.board   = tetris;
    in_frame.total   = tfs_sat255(acc, score_valid ? score : 4'd0);
  end

  tfs_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_now),
    .push_data (in_frame),
    .pop       (pop_now),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Score accumulation, game numbering and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      game_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (tetris_valid) begin
        acc      <= '0;
        game_cnt <= game_cnt + GAME_W'(1);
      end else if (score_valid) begin
        acc <= tfs_sat255(acc, score);
      end
      if (drop_now) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  // Readout. Output registers are loaded with the byte that will be visible
  // after this edge; the next header comes from the entry behind the head, or
  // straight from the incoming frame when the FIFO would otherwise be empty,
  // which gives one-cycle capture latency and bubble-free back-to-back frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (state == IDLE) begin
      if (push_now) begin
        state     <= SEND;
        beat      <= '0;
        out_valid <= 1'b1;
        out_data  <= tfs_beat_byte(in_frame, 4'd0);
        out_last  <= 1'b0;
      end
    end else if (handshake) begin
      if (beat != 4'd13) begin
        beat     <= beat + 4'd1;
        out_data <= tfs_beat_byte(fifo_head, beat + 4'd1);
        out_last <= (beat == 4'd12);
      end else if (fifo_count > CW'(1)) begin
        beat     <= '0;
        out_data <= tfs_beat_byte(fifo_head_next, 4'd0);
        out_last <= 1'b0;
      end else if (push_now) begin
        beat     <= '0;
        out_data <= tfs_beat_byte(in_frame, 4'd0);
        out_last <= 1'b0;
      end else begin
        state     <= IDLE;
        beat      <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
